// File: rtl/color_pkg.sv
// color_pkg: shared widths, default bin codes and scan FSM states for color_contour.
// Contents: BIN_W/ADDR_W widths, BACKGROUND/CONTOUR_CODE defaults, state_e enum.
// No logic; imported by color_contour and contour_line_buffer.
package color_pkg;

  localparam int BIN_W  = 3;
  localparam int ADDR_W = 19;

  localparam logic [BIN_W-1:0] BACKGROUND   = 3'd0;
  localparam logic [BIN_W-1:0] CONTOUR_CODE = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    EVAL,
    WRITE,
    ADVANCE,
    DONE
  } state_e;

endpackage

// File: rtl/contour_line_buffer.sv
// contour_line_buffer: one row of original (pre-marking) bins, indexed by x.
// Ports: clk; synchronous write (we_i, waddr_i, wdata_i); asynchronous read port A
//        (raddr_a_i/rdata_a_o); port B (raddr_b_i/rdata_b_o) only with COLOR_CONTOUR_DIAG_EN.
module contour_line_buffer
  import color_pkg::*;
#(
  parameter int H_PIXELS = 640,
  parameter int IDX_W    = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [BIN_W-1:0] wdata_i,
  input  logic [IDX_W-1:0] raddr_a_i,
  output logic [BIN_W-1:0] rdata_a_o
`ifdef COLOR_CONTOUR_DIAG_EN
  ,
  input  logic [IDX_W-1:0] raddr_b_i,
  output logic [BIN_W-1:0] rdata_b_o
`endif
);

  // No reset: entries are always written in row 0 before they are read in row 1.
  logic [BIN_W-1:0] mem_q [H_PIXELS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
`ifdef COLOR_CONTOUR_DIAG_EN
  assign rdata_b_o = mem_q[raddr_b_i];
`endif

endmodule

// File: rtl/color_contour.sv
// color_contour: single pass over the xy_bin frame buffer, overwriting every non-background
// pixel on an upper/left colour boundary with CONTOUR_CODE, then holding done until next start.
// Ports: clk, reset (sync, active-high), start; BRAM port bram_addr/xy_bin_in/xy_bin_en/
// xy_bin_we/xy_bin_out; status done, busy, contour_count. Macro COLOR_CONTOUR_DIAG_EN adds UL/UR.
module color_contour
  import color_pkg::*;
#(
  parameter int               H_PIXELS     = 640,
  parameter int               V_PIXELS     = 480,
  parameter int               READ_LATENCY = 2,
  parameter logic [BIN_W-1:0] BACKGROUND   = color_pkg::BACKGROUND,
  parameter logic [BIN_W-1:0] CONTOUR_CODE = color_pkg::CONTOUR_CODE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [BIN_W-1:0]  xy_bin_in,
  output logic              xy_bin_en,
  output logic              xy_bin_we,
  input  logic [BIN_W-1:0]  xy_bin_out,
  output logic              done,
  output logic              busy,
  output logic [ADDR_W-1:0] contour_count
);

  localparam int NPIX   = H_PIXELS * V_PIXELS;
  localparam int X_W    = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int Y_W    = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1;
  localparam int WAIT_W = $clog2(READ_LATENCY + 1);
  localparam logic [X_W-1:0]    X_LAST    = X_W'(H_PIXELS - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NPIX - 1);

  if (NPIX > (1 << ADDR_W)) begin : g_size_chk
    $error("color_contour: H_PIXELS*V_PIXELS does not fit the 19-bit BRAM address");
  end
  if (READ_LATENCY < 1) begin : g_lat_chk
    $error("color_contour: READ_LATENCY must be at least 1");
  end

  state_e              state_q, state_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BIN_W-1:0]    left_q, left_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                en_q, we_q, busy_q, done_q;
  logic [BIN_W-1:0]    din_q;

  logic                lb_we;
  logic [BIN_W-1:0]    lb_up, up_bin;
  logic                boundary;
`ifdef COLOR_CONTOUR_DIAG_EN
  logic [BIN_W-1:0]    ul_q, ul_d;
  logic [BIN_W-1:0]    lb_ur, ur_bin;
  logic [X_W-1:0]      ur_idx;
`endif

  // The line buffer is refreshed with the original bin in EVAL, so the BRAM
  // can be overwritten in place without affecting the next row's comparisons.
  assign lb_we = (state_q == EVAL);

`ifdef COLOR_CONTOUR_DIAG_EN
  assign ur_idx = (x_q == X_LAST) ? '0 : x_q + 1'b1;
`endif

  contour_line_buffer #(
    .H_PIXELS (H_PIXELS),
    .IDX_W    (X_W)
  ) u_line_buf (
    .clk       (clk),
    .we_i      (lb_we),
    .waddr_i   (x_q),
    .wdata_i   (xy_bin_out),
    .raddr_a_i (x_q),
    .rdata_a_o (lb_up)
`ifdef COLOR_CONTOUR_DIAG_EN
    ,
    .raddr_b_i (ur_idx),
    .rdata_b_o (lb_ur)
`endif
  );

  // Out-of-frame neighbours read as BACKGROUND; left/UL registers are
  // reset to BACKGROUND at each row start so x=0 needs no extra masking.
  always_comb begin
    up_bin   = (y_q == '0) ? BACKGROUND : lb_up;
    boundary = (xy_bin_out != BACKGROUND) &&
               ((left_q != xy_bin_out) || (up_bin != xy_bin_out));
`ifdef COLOR_CONTOUR_DIAG_EN
    ur_bin   = ((y_q == '0) || (x_q == X_LAST)) ? BACKGROUND : lb_ur;
    boundary = boundary || ((xy_bin_out != BACKGROUND) &&
               ((ul_q != xy_bin_out) || (ur_bin != xy_bin_out)));
`endif
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    left_d  = left_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
`ifdef COLOR_CONTOUR_DIAG_EN
    ul_d    = ul_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = READ;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
          cnt_d   = '0;
          left_d  = BACKGROUND;
`ifdef COLOR_CONTOUR_DIAG_EN
          ul_d    = BACKGROUND;
`endif
        end
      end
      READ: begin
        if (READ_LATENCY > 1) begin
          state_d = WAIT;
          wait_d  = WAIT_W'(READ_LATENCY - 2);
        end else begin
          state_d = EVAL;
        end
      end
      WAIT: begin
        if (wait_q == '0) state_d = EVAL;
        else              wait_d  = wait_q - 1'b1;
      end
      EVAL: begin
        left_d  = xy_bin_out;
`ifdef COLOR_CONTOUR_DIAG_EN
        // Row-above value at x becomes the upper-left neighbour of x+1.
        ul_d    = up_bin;
`endif
        state_d = boundary ? WRITE : ADVANCE;
      end
      WRITE: begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        state_d = ADVANCE;
      end
      ADVANCE: begin
        if (addr_q == ADDR_LAST) begin
          state_d = DONE;
        end else begin
          state_d = READ;
          addr_d  = addr_q + 1'b1;
          if (x_q == X_LAST) begin
            x_d    = '0;
            y_d    = y_q + 1'b1;
            left_d = BACKGROUND;
`ifdef COLOR_CONTOUR_DIAG_EN
            ul_d   = BACKGROUND;
`endif
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state that owns them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      left_q  <= BACKGROUND;
      cnt_q   <= '0;
      wait_q  <= '0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      din_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef COLOR_CONTOUR_DIAG_EN
      ul_q    <= BACKGROUND;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
      left_q  <= left_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      en_q    <= (state_d == READ) || (state_d == WRITE);
      we_q    <= (state_d == WRITE);
      din_q   <= (state_d == WRITE) ? CONTOUR_CODE : '0;
      busy_q  <= (state_d != IDLE) && (state_d != DONE);
      done_q  <= (state_d == DONE);
`ifdef COLOR_CONTOUR_DIAG_EN
      ul_q    <= ul_d;
`endif
    end
  end

  assign bram_addr     = addr_q;
  assign xy_bin_in     = din_q;
  assign xy_bin_en     = en_q;
  assign xy_bin_we     = we_q;
  assign done          = done_q;
  assign busy          = busy_q;
  assign contour_count = cnt_q;

endmodule

// File: tb/tb_color_contour.sv
// tb_color_contour: two color_contour instances (8x4 frame, READ_LATENCY 2 and 1) each with
// a behavioural BRAM; directed frames with hand-computed write sets, plus reset/start corners.
// Respects COLOR_CONTOUR_DIAG_EN when choosing expected write sets.
module tb_color_contour;

  localparam int H    = 8;
  localparam int V    = 4;
  localparam int NPIX = H * V;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, load;
  logic [95:0] load_frame;

  logic [18:0] addr_v [2];
  logic [2:0]  din_v  [2];
  logic        en_v   [2];
  logic        we_v   [2];
  logic [2:0]  dout_v [2];
  logic        done_v [2];
  logic        busy_v [2];
  logic [18:0] cnt_v  [2];
  logic [95:0] mem_v  [2];
  int          wcnt_v [2];
  logic        bad_v  [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int RL = (g == 0) ? 2 : 1;
    logic [95:0] mem;
    logic [2:0]  pipe [RL];
    int          wcnt;
    logic        bad;

    color_contour #(
      .H_PIXELS(H), .V_PIXELS(V), .READ_LATENCY(RL),
      .BACKGROUND(3'd0), .CONTOUR_CODE(3'd7)
    ) dut (
      .clk(clk), .reset(reset), .start(start),
      .bram_addr(addr_v[g]), .xy_bin_in(din_v[g]), .xy_bin_en(en_v[g]),
      .xy_bin_we(we_v[g]), .xy_bin_out(dout_v[g]),
      .done(done_v[g]), .busy(busy_v[g]), .contour_count(cnt_v[g])
    );

    // BRAM model: data of a read issued in cycle t is presented in cycle t+RL.
    always @(posedge clk) begin
      if (load) begin
        mem  <= load_frame;
        wcnt <= 0;
        bad  <= 1'b0;
      end else if (en_v[g]) begin
        if (addr_v[g] >= 19'(NPIX)) begin
          bad <= 1'b1;
        end else if (we_v[g]) begin
          mem[3*addr_v[g][4:0] +: 3] <= din_v[g];
          wcnt <= wcnt + 1;
        end else begin
          pipe[0] <= mem[3*addr_v[g][4:0] +: 3];
        end
      end
      for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end

    assign dout_v[g] = pipe[RL-1];
    assign mem_v[g]  = mem;
    assign wcnt_v[g] = wcnt;
    assign bad_v[g]  = bad;
  end

  typedef struct {
    string       name;
    logic [95:0] frame;
    logic [31:0] wmask;
    int          cnt;
  } vec_t;

  vec_t vecs [5];
  int   checks = 0;
  int   failures = 0;
  int   busy_cyc [2];
  int   done_at [2];
  int   last_busy [2];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [95:0] put(input logic [95:0] f, input int x, input int y,
                                      input logic [2:0] v);
    logic [95:0] r;
    r = f;
    r[3*(y*H + x) +: 3] = v;
    return r;
  endfunction

  function automatic logic [95:0] exp_mem(input logic [95:0] f, input logic [31:0] m);
    logic [95:0] r;
    r = f;
    for (int i = 0; i < NPIX; i++) if (m[i]) r[3*i +: 3] = 3'd7;
    return r;
  endfunction

  task automatic load_mem(input logic [95:0] f);
    @(negedge clk);
    load_frame = f;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Pulses start, then samples every cycle at the falling edge until both DUTs
  // report done; extra_start re-pulses start in that cycle of the scan.
  task automatic run_scan(input int extra_start);
    int cyc;
    bit fin [2];
    for (int g = 0; g < 2; g++) begin
      busy_cyc[g] = 0; done_at[g] = -1; last_busy[g] = -1; fin[g] = 1'b0;
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    for (int g = 0; g < 2; g++) begin
      check($sformatf("rl%0d_first_cycle_status", 2 - g),
            {done_v[g], busy_v[g], en_v[g], we_v[g], addr_v[g]}, {4'b0110, 19'd0});
    end
    while (!(fin[0] && fin[1]) && cyc < 2000) begin
      for (int g = 0; g < 2; g++) begin
        if (!fin[g]) begin
          if (busy_v[g]) begin
            busy_cyc[g]++;
            last_busy[g] = cyc;
          end
          if (done_v[g]) begin
            done_at[g] = cyc;
            fin[g] = 1'b1;
          end
        end
      end
      start = (cyc == extra_start);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    for (int g = 0; g < 2; g++) check($sformatf("rl%0d_done_reached", 2 - g), fin[g], 1);
  endtask

  task automatic check_vec(input vec_t v);
    int    rl;
    string p;
    for (int g = 0; g < 2; g++) begin
      rl = 2 - g;
      p  = $sformatf("%s_rl%0d", v.name, rl);
      check({p, "_busy_cycles"}, busy_cyc[g], NPIX*(2+rl) + v.cnt);
      check({p, "_done_cycle"},  done_at[g],  NPIX*(2+rl) + v.cnt + 1);
      check({p, "_busy_fall"},   last_busy[g] + 1, done_at[g]);
      check({p, "_count"},       cnt_v[g],  v.cnt);
      check({p, "_writes"},      wcnt_v[g], v.cnt);
      check({p, "_frame"},       mem_v[g],  exp_mem(v.frame, v.wmask));
      check({p, "_addr_range"},  bad_v[g],  0);
      check({p, "_done_state"},  {done_v[g], busy_v[g], en_v[g], we_v[g]}, 4'b1000);
    end
  endtask

  initial begin
    vec_t        t;
    logic [95:0] f;

    reset = 1'b1; start = 1'b0; load = 1'b0; load_frame = '0;

    vecs[0] = '{name: "zero",   frame: '0, wmask: 32'h0, cnt: 0};
    vecs[1] = '{name: "single", frame: put('0, 3, 1, 3'd2), wmask: 32'h0000_0800, cnt: 1};
    f = '0;
    for (int y = 1; y <= 2; y++) for (int x = 2; x <= 5; x++) f = put(f, x, y, 3'd3);
`ifdef COLOR_CONTOUR_DIAG_EN
    vecs[2] = '{name: "rect", frame: f, wmask: 32'h0024_3C00, cnt: 6};
`else
    vecs[2] = '{name: "rect", frame: f, wmask: 32'h0004_3C00, cnt: 5};
`endif
    f = '0;
    for (int y = 0; y < V; y++) for (int x = 0; x < H; x++) f = put(f, x, y, (x < 4) ? 3'd1 : 3'd4);
`ifdef COLOR_CONTOUR_DIAG_EN
    vecs[3] = '{name: "vsplit", frame: f, wmask: 32'h9999_99FF, cnt: 20};
`else
    vecs[3] = '{name: "vsplit", frame: f, wmask: 32'h1111_11FF, cnt: 14};
`endif
    // Row 1 holds original 7s under row-0 pixels that get rewritten to 7.
    f = put('0, 2, 0, 3'd2);
    f = put(f, 3, 0, 3'd2);
    f = put(f, 2, 1, 3'd7);
    f = put(f, 3, 1, 3'd7);
    vecs[4] = '{name: "code7", frame: f, wmask: 32'h0000_0C0C, cnt: 4};

    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("rl%0d_reset_state", 2 - g),
            {addr_v[g], din_v[g], en_v[g], we_v[g], done_v[g], busy_v[g], cnt_v[g]},
            {19'd0, 3'd0, 4'b0000, 19'd0});
    end
    reset = 1'b0;

    for (int v = 0; v < 5; v++) begin
      load_mem(vecs[v].frame);
      run_scan(0);
      check_vec(vecs[v]);
    end

    // start pulsed mid-scan must not disturb timing or results.
    t = vecs[0];
    t.name = "start_busy";
    load_mem(t.frame);
    run_scan(10);
    check_vec(t);

    // Reset in cycle 40 of a scan.
    load_mem(vecs[3].frame);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 40; c++) @(negedge clk);
    for (int g = 0; g < 2; g++) check($sformatf("rl%0d_busy_before_reset", 2 - g), busy_v[g], 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int g = 0; g < 2; g++) begin
      check($sformatf("rl%0d_after_midscan_reset", 2 - g),
            {en_v[g], we_v[g], busy_v[g], done_v[g], cnt_v[g]}, {4'b0000, 19'd0});
    end
    t = vecs[3];
    t.name = "after_reset";
    load_mem(t.frame);
    run_scan(0);
    check_vec(t);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
